// File: rtl/multi_div_detector_pkg.sv
// Shared types and default constants for the multi-divisor detector.
// Optional feature macro: MDD_HIT_COUNT_EN (per-channel hit counters).
package multi_div_detector_pkg;

   // Controller states: wait for an operand, shift it through, present the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdd_state_e;

   // Default divisor table {5,4,3,2}; channel 0 sits in the LSB byte.
   localparam logic [31:0] DEF_DIVS     = {8'd5, 8'd4, 8'd3, 8'd2};
   localparam logic [3:0]  DEF_ALL_MASK = 4'b1011;
   localparam int unsigned DEF_CNT_W    = 16;

endpackage : multi_div_detector_pkg

// File: rtl/multi_div_detector_if.sv
// Operand/result handshake bundle for the multi-divisor detector.
// hit_cnt exists only when MDD_HIT_COUNT_EN is defined.
interface multi_div_detector_if
   import multi_div_detector_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = DEF_CNT_W
) ();

   logic [WIDTH-1:0]     num;
   logic                 in_valid;
   logic                 in_ready;
   logic [NCH-1:0]       div;
   logic                 all_div;
   logic                 out_valid;
   logic                 out_ready;
`ifdef MDD_HIT_COUNT_EN
   logic [NCH*CNT_W-1:0] hit_cnt;
`endif

   // Requester side: supplies operands and consumes results.
   modport master (
      output num, in_valid, out_ready,
`ifdef MDD_HIT_COUNT_EN
      input  hit_cnt,
`endif
      input  in_ready, div, all_div, out_valid
   );

   // Detector side.
   modport slave (
      input  num, in_valid, out_ready,
`ifdef MDD_HIT_COUNT_EN
      output hit_cnt,
`endif
      output in_ready, div, all_div, out_valid
   );

endinterface : multi_div_detector_if

// File: rtl/multi_div_detector_div_rem_ch.sv
// One divisor channel: WIDTH+1-bit restoring remainder, fed one operand bit
// per step, MSB first. rem_zero reports divisibility (never for divisor 0).
module div_rem_ch #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step,
   input  logic             ser_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic             rem_zero
);

   logic [WIDTH:0] rem_q;
   logic [WIDTH:0] rem_d;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisor_ext;

   // rem_q < divisor < 2^WIDTH, so its top bit is always 0 and dropping it
   // in the shift loses nothing.
   assign divisor_ext = {1'b0, divisor};
   assign shifted     = {rem_q[WIDTH-1:0], ser_bit};

   // Next remainder: clear on accept, one restoring step when enabled, else hold.
   always_comb begin
      // NOTE: default assigned first so every path drives rem_d; without it a latch is inferred.
      rem_d = rem_q;
      if (clear) begin
         rem_d = '0;
      end else if (step) begin
         if (shifted >= divisor_ext) begin
            rem_d = shifted - divisor_ext;
         end else begin
            rem_d = shifted;
         end
      end
   end

   // Remainder register with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking so all flops update from pre-edge values regardless of block order.
      if (rst) begin
         rem_q <= '0;
      end else begin
         rem_q <= rem_d;
      end
   end

   assign rem_zero = (rem_q == '0) && (divisor != '0);

endmodule : div_rem_ch

// File: rtl/multi_div_detector.sv
// Multi-divisor detector: accepts an operand, runs WIDTH bit-serial restoring
// steps in NCH parallel channels, then presents div/all_div until taken.
// Optional feature macro: MDD_HIT_COUNT_EN adds saturating per-channel hit counters.
module multi_div_detector
   import multi_div_detector_pkg::*;
#(
   parameter int unsigned               WIDTH    = 8,
   parameter int unsigned               NCH      = 4,
   parameter logic [NCH-1:0][WIDTH-1:0] DIVS     = DEF_DIVS,
   parameter logic [NCH-1:0]            ALL_MASK = DEF_ALL_MASK,
   parameter int unsigned               CNT_W    = DEF_CNT_W
) (
   input logic                 clk,
   input logic                 rst,
   multi_div_detector_if.slave bus
);

   // Counter must reach WIDTH itself: WIDTH step cycles plus one finishing cycle.
   localparam int unsigned      CNT_BW   = $clog2(WIDTH + 1);
   localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(WIDTH);

   mdd_state_e        state_q, state_d;
   logic [WIDTH-1:0]  num_q, num_d;
   logic [CNT_BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [NCH-1:0]    div_q, div_d;
   logic              all_div_q, all_div_d;

   logic              rem_clear;
   logic              rem_step;
   logic              ser_bit;
   logic [NCH-1:0]    rem_zero;
   logic              all_hit;

   // The operand shifts left so its MSB is always the next bit to feed.
   assign ser_bit = num_q[WIDTH-1];

   // A channel outside the mask counts as satisfied; an empty mask yields 0.
   assign all_hit = (ALL_MASK != '0) && ((rem_zero | ~ALL_MASK) == '1);

   // One remainder engine per divisor channel.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      div_rem_ch #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .clear    (rem_clear),
         .step     (rem_step),
         .ser_bit  (ser_bit),
         .divisor  (DIVS[i]),
         .rem_zero (rem_zero[i])
      );
   end

   // Next-state and datapath control for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      bit_cnt_d = bit_cnt_q;
      div_d     = div_q;
      all_div_d = all_div_q;
      rem_clear = 1'b0;
      rem_step  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               num_d     = bus.num;
               bit_cnt_d = '0;
               rem_clear = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            if (bit_cnt_q == LAST_CNT) begin
               // All bits consumed: capture the verdict on the way into DONE.
               div_d     = rem_zero;
               all_div_d = all_hit;
               state_d   = DONE;
            end else begin
               rem_step  = 1'b1;
               num_d     = {num_q[WIDTH-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + CNT_BW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         num_q     <= '0;
         bit_cnt_q <= '0;
         div_q     <= '0;
         all_div_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         bit_cnt_q <= bit_cnt_d;
         div_q     <= div_d;
         all_div_q <= all_div_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.div       = div_q;
   assign bus.all_div   = all_div_q;

`ifdef MDD_HIT_COUNT_EN
   logic [NCH-1:0][CNT_W-1:0] hit_cnt_q, hit_cnt_d;

   // Bump each hit channel once per completed result transfer, saturating.
   always_comb begin
      hit_cnt_d = hit_cnt_q;
      if ((state_q == DONE) && bus.out_ready) begin
         for (int i = 0; i < NCH; i++) begin
            if (div_q[i] && (hit_cnt_q[i] != '1)) begin
               hit_cnt_d[i] = hit_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Hit counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
      end
   end

   assign bus.hit_cnt = hit_cnt_q;
`endif

endmodule : multi_div_detector

// File: doc/multi_div_detector.md
MULTI_DIV_DETECTOR -- requirements
Module: multi_div_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter NCH, default 4, giving the number of divisor channels.
REQ-003 The block SHALL have parameter DIVS, default {5,4,3,2}, a packed array of NCH divisors of WIDTH bits each; channel 0 is the LSB entry.
REQ-004 The block SHALL have parameter ALL_MASK, default 4'b1011, an NCH-bit mask selecting the channels that feed all_div.
REQ-005 The block SHALL have parameter CNT_W, default 16, giving the hit-counter width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port num, input, WIDTH bits: the operand, unsigned.
REQ-009 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the operand handshake.
REQ-010 The block SHALL have port div, output, NCH bits: bit i is 1 when num is divisible by DIVS[i].
REQ-011 The block SHALL have port all_div, output, 1 bit: the AND of div over the channels selected by ALL_MASK.
REQ-012 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.
REQ-013 The block SHALL have port hit_cnt, output, NCH*CNT_W bits, present only with MDD_HIT_COUNT_EN: per-channel hit counts, channel 0 in the LSBs.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 IDLE with in_valid=1 SHALL accept the operand: latch num, clear all remainders and the bit counter, and go to CALC.
REQ-016 CALC SHALL run bit-serial restoring remainder per channel, MSB first: rem = {rem,bit}, and if rem >= DIVS[i] then rem -= DIVS[i]. One bit per cycle, exactly WIDTH cycles, then DONE.
REQ-017 Remainder arithmetic SHALL be WIDTH+1 bits wide so the shift never overflows.
REQ-018 Latency: when accepted at edge T, out_valid SHALL rise at edge T+WIDTH+1 (9 cycles for the default).
REQ-019 On entry to DONE, div[i] SHALL be registered as (rem_i == 0), and all_div SHALL be registered as well.
REQ-020 div and all_div SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, out_ready=1 SHALL complete the transfer and go to IDLE; the next operand is accepted no earlier than the following cycle.
REQ-022 Boundary: num=0 SHALL give every channel with a nonzero divisor div=1.
REQ-023 Boundary: a channel with DIVS[i]=0 SHALL always report 0.
REQ-024 Boundary: a channel with DIVS[i]=1 SHALL always report 1.
REQ-025 Boundary: ALL_MASK=0 SHALL give all_div=0.
REQ-026 in_valid outside IDLE SHALL be ignored, and num outside IDLE SHALL not affect the result.

Reset
REQ-027 rst=1 SHALL immediately force IDLE and clear the remainders, bit counter, div and all_div; in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-028 Reset mid-CALC or mid-DONE SHALL discard the operation with no output.
REQ-029 Hit counters SHALL reset to 0.

Configuration
REQ-030 With macro MDD_HIT_COUNT_EN defined: each DONE handshake SHALL increment hit_cnt[i] for every set div[i], saturating at all-ones; the hit_cnt port SHALL exist.
REQ-031 Without MDD_HIT_COUNT_EN: there SHALL be no counters and no hit_cnt port, and all other behaviour SHALL be identical.

Structure
REQ-032 Package multi_div_detector_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the default DIVS, ALL_MASK and CNT_W constants.
REQ-033 Sub-module div_rem_ch SHALL implement one channel's WIDTH+1-bit remainder register and restoring step (inputs: clk, rst, clear, step enable, serial bit, divisor; output: rem_zero); it SHALL be instantiated NCH times via generate.

Verification
REQ-034 Scenario, defaults: num=30, out_ready=1 -> div=4'b1011, all_div=1, out_valid at edge T+9 for exactly one cycle.
REQ-035 Scenario: num=255 -> div=4'b1010, all_div=0.
REQ-036 Scenario: num=0 -> div=4'b1111, all_div=1.
REQ-037 Scenario: num=12 with out_ready held 0 for 5 cycles -> div=4'b0111 stable, out_valid=1 and in_ready=0 throughout; completes on the first out_ready=1.
REQ-038 Scenario: rst pulse at CALC cycle 4 -> next cycle state IDLE, out_valid=0, and the next operand num=10 yields div=4'b1001 with full latency.
REQ-039 Scenario, MDD_HIT_COUNT_EN with CNT_W=2: four results of num=4 -> channel-2 count goes 1,2,3,3 (saturates) and channel-1 count stays 0.
